// File: rtl/mask_and_arbiter_pkg.sv
// Shared definitions for the mask_and_arbiter block.
// - state_e   : output-register FSM state (IDLE = empty, HOLD = result held)
// - SRC0/SRC1 : requester indices used by the arbiter and on out_src
package mask_and_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage : mask_and_arbiter_pkg

// File: rtl/mask_and_arbiter_if.sv
// Handshake bundle between the two producers, the mask/arbiter block and the
// single consumer.
// - req0_*/req1_* : valid/data from each producer, ready back to it
// - out_*         : registered result (valid/data/src) to the consumer, ready back
// Modports: slave = the mask_and_arbiter block, master = producers + consumer.
interface mask_and_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output out_valid, out_data, out_src,
        input  out_ready
    );

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  out_valid, out_data, out_src,
        output out_ready
    );
endinterface : mask_and_arbiter_if

// File: rtl/mask_and_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// - valid0/valid1 : request lines
// - rr_last       : index of the previous winner
// - en            : arbitration allowed this cycle
// - grant         : winning requester index (SRC0 when nothing wins)
// - gnt_valid     : a winner exists and en is high
module rr_arb2
    import mask_and_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    input  logic en,
    output logic grant,
    output logic gnt_valid
);

    // NOTE: every output gets a default before the if-chain so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = SRC0;
        gnt_valid = 1'b0;
        if (en) begin
            gnt_valid = valid0 | valid1;
            if (valid0 && valid1) begin
                // Contention: the requester that did not win last time goes.
                grant = (rr_last == SRC0) ? SRC1 : SRC0;
            end else if (valid1) begin
                grant = SRC1;
            end else begin
                grant = SRC0;
            end
        end
    end

endmodule : rr_arb2

// File: rtl/mask_and_arbiter.sv
// Shared AND-mask datapath serving two requesters with round-robin arbitration.
// The accepted operand is masked and registered; the result is held until the
// consumer takes it, with a new operand accepted in the same cycle for full
// throughput.
// Ports:
// - clk, rst_n       : clock, asynchronous active-low reset
// - cfg_we, cfg_mask : mask write strobe and new mask value
// - mask_q           : current mask (resets to all ones)
// - done_cnt         : saturating count of delivered results
// - bus              : requester/consumer handshakes (slave modport)
module mask_and_arbiter
    import mask_and_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic [WIDTH-1:0] mask_q,
    output logic [CNT_W-1:0] done_cnt,
    mask_and_arbiter_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             grant;
    logic             gnt_valid;
    logic             rr_last;
    logic             deliver;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;

    // The output register can take a new result when it is empty, or when the
    // held result leaves in this same cycle.
    assign accept  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign deliver = (state_q == HOLD) && bus.out_ready;

    rr_arb2 u_arb (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .rr_last   (rr_last),
        .en        (accept),
        .grant     (grant),
        .gnt_valid (gnt_valid)
    );

    assign win_data       = (grant == SRC1) ? bus.req1_data : bus.req0_data;
    assign bus.req0_ready = gnt_valid && (grant == SRC0);
    assign bus.req1_ready = gnt_valid && (grant == SRC1);

    // Outputs come straight from registers, so out_ready never reaches out_data.
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    // FSM next state: a winner always fills the register; otherwise a taken
    // result empties it.
    always_comb begin
        state_d = state_q;
        if (gnt_valid) begin
            state_d = HOLD;
        end else if (deliver) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register and round-robin pointer. mask_q here is the value before
    // any same-cycle cfg write, so a new mask applies from the next accept on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_src_q  <= SRC0;
            rr_last    <= SRC1;
        end else if (gnt_valid) begin
            out_data_q <= mask_q & win_data;
            out_src_q  <= grant;
            rr_last    <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
        end else if (cfg_we) begin
            mask_q <= cfg_mask;
        end
    end

    // Delivered-result counter sticks at all ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (deliver && (done_cnt != '1)) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule : mask_and_arbiter

// File: doc/mask_and_arbiter.md
Name: mask_and_arbiter

Overview:
- Shared AND-mask datapath (result = mask & data) serving two requesters via round-robin arbitration, with a registered, handshaked result.
- The mask register is explicitly reset and written before any reference, so the combinational mask path never reads an unassigned variable.
- Sits between producer ports and a single consumer.
- Also configures the mask and counts delivered results.

Parameters:
- WIDTH, 8, data/mask width in bits
- CNT_W, 16, width of the delivered-result counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  mask write strobe
- cfg_mask  input  WIDTH  new mask value
- req0_valid  input  1  requester 0 has data
- req0_data  input  WIDTH  requester 0 operand
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has data
- req1_data  input  WIDTH  requester 1 operand
- req1_ready  output  1  requester 1 accepted this cycle
- out_valid  output  1  result held
- out_data  output  WIDTH  mask & accepted data
- out_src  output  1  requester that produced out_data
- out_ready  input  1  consumer takes result
- mask_q  output  WIDTH  current mask
- done_cnt  output  CNT_W  results delivered, saturating

Behaviour:
- Reset values (async, rst_n low):
  - mask_q = all ones
  - out_valid = 0, out_data = 0, out_src = 0
  - done_cnt = 0
  - FSM = IDLE
  - rr_last = 1, so requester 0 has priority first
- FSM states:
  - IDLE: output empty.
  - HOLD: output register full, waiting for out_ready.
- Accept condition: accept = (state==IDLE) or (state==HOLD and out_ready). This gives full throughput, one result per cycle under back-to-back acceptance.
- Arbitration (combinational, evaluated when accept is true):
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to rr_last wins.
  - reqN_ready = accept and grant==N. At most one ready is high per cycle.
  - rr_last updates to the winner on every accept with a winner.
- On an accept with a winner:
  - out_data <= mask_q & winner data, using the mask value before any same-cycle write.
  - out_src <= winner.
  - out_valid <= 1; state -> HOLD.
- HOLD with out_ready and no winner: out_valid <= 0, state -> IDLE.
- HOLD without out_ready: out_data and out_src hold stable, and both readies are 0.
- done_cnt increments on each out_valid & out_ready and saturates at all ones (no wrap).
- Mask write: cfg_we=1 loads mask_q <= cfg_mask at the clock edge. The new value applies to acceptances from the next cycle on.
- Reset mid-operation: a result held in the output register is discarded, and all state returns to reset values immediately (asynchronous).
- No combinational path from out_ready to out_data. A combinational path from out_ready to reqN_ready is permitted.

Decomposition:
- Shared package holds:
  - FSM state constants (IDLE=1'b0, HOLD=1'b1)
  - requester index constants (SRC0=0, SRC1=1)
- One sub-module is natural: rr_arb2 (2-way round-robin arbiter; inputs valid0, valid1, rr_last, en; outputs grant, gnt_valid).
- Everything else stays in the top module.

Test Plan:
- Reset, then req0_valid=1, data=8'hA5, cfg never written -> next cycle out_valid=1, out_data=8'hA5, out_src=0 (mask reset to 8'hFF, never undefined).
- cfg_we=1, cfg_mask=8'h0F in the same cycle as req0 accept, data=8'hFF -> out_data=8'hFF (old mask); a following req with data 8'hFF -> out_data=8'h0F.
- Both requesters valid continuously, out_ready=1, data0=8'h11, data1=8'h22 -> out_src alternates 0,1,0,1; out_data alternates 8'h11, 8'h22; one result per cycle.
- out_ready=0 for 3 cycles while HOLD -> out_data stable, req0_ready=req1_ready=0, done_cnt unchanged; out_ready=1 -> done_cnt+1.
- Assert rst_n low asynchronously mid-HOLD -> out_valid=0, done_cnt=0, mask_q=8'hFF immediately without a clock edge.
- Preload done_cnt to all ones (CNT_W=4, 15 deliveries), deliver one more -> done_cnt stays 4'hF.
